// File: rtl/orb_frame_filler.sv
// Ping-pong word buffer for the orbit frame former. A fill engine writes a test frame into the idle bank while the former reads the active bank.
// Latency: dataWord updates 4 clk after a rising edge on bufGetWord (2-FF sync, edge detect, RAM read, output register).
// Backpressure: none; one read per request level. A frame wrap before the idle bank is full re-serves the old bank and sets oOverrun.
// Ports: clk/reset (async, active high); bufGetWord + bufRdPointer read request from the former;
//        dataWord read data; oReady initial fill done; oOverrun sticky late-fill flag; oFrameCnt frame being served.
module orb_frame_filler #(
    parameter int                ADDR_W      = 11,
    parameter int                WORD_W      = 12,
    parameter int                FRAME_WORDS = 2048,
    parameter logic [WORD_W-1:0] SYNC_WORD   = 12'hF0F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bufGetWord,
    input  logic [ADDR_W-1:0] bufRdPointer,
    output logic [WORD_W-1:0] dataWord,
    output logic              oReady,
    output logic              oOverrun,
    output logic [15:0]       oFrameCnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [ADDR_W:0]   FW_EXT    = (ADDR_W + 1)'(FRAME_WORDS);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_FILL,
        ST_DONE
    } fill_state_t;

    // Request synchroniser and edge detector
    logic sync1_q, sync2_q, sync3_q;

    // Fill engine
    fill_state_t       state_q;
    logic [ADDR_W-1:0] fill_addr_q;
    logic              fill_bank_q;
    logic [15:0]       fill_frame_q;

    // Read side
    logic              rd_bank_q;
    logic [15:0]       frame_cnt_q;
    logic              ready_q;
    logic              overrun_q;
    logic              rd_pend_q;
    logic              rd_ok_q;
    logic [WORD_W-1:0] rd_word_q;
    logic [WORD_W-1:0] data_q;

    logic [WORD_W-1:0] mem [2**(ADDR_W+1)];

    logic              req;
    logic              in_range;
    logic              rd_valid;
    logic              swap_req;
    logic              swap_ok;
    logic              fill_active;
    logic              fill_last;
    logic [WORD_W-1:0] fill_dat;

    assign req         = sync2_q & ~sync3_q;
    assign in_range    = {1'b0, bufRdPointer} < FW_EXT;
    // Before the first fill completes the RAM is only partly written, so reads return zero.
    assign rd_valid    = req & ready_q & in_range;
    assign swap_req    = rd_valid & (bufRdPointer == LAST_ADDR);
    assign fill_active = (state_q != ST_DONE);
    assign fill_last   = fill_active & (fill_addr_q == LAST_ADDR);
    // A fill finishing in the same clk as the wrap read counts as complete.
    assign swap_ok     = (state_q == ST_DONE) | ((state_q == ST_FILL) & fill_last);

    always_comb begin
        fill_dat = WORD_W'(fill_addr_q) + fill_frame_q[WORD_W-1:0];
        if (fill_addr_q == '0) begin
            fill_dat = SYNC_WORD;
        end else if (fill_addr_q == ADDR_W'(1)) begin
            fill_dat = fill_frame_q[WORD_W-1:0];
        end
    end

    // RAM: one write port (fill), one registered read port (former).
    // Reads are gated by rd_valid, so during INIT (fill into bank 0) bank 0 is never read.
    always_ff @(posedge clk) begin
        if (fill_active) begin
            mem[{fill_bank_q, fill_addr_q}] <= fill_dat;
        end
        if (rd_valid) begin
            rd_word_q <= mem[{rd_bank_q, bufRdPointer}];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            state_q      <= ST_INIT;
            fill_addr_q  <= '0;
            fill_bank_q  <= 1'b0;
            fill_frame_q <= '0;
            rd_bank_q    <= 1'b0;
            frame_cnt_q  <= '0;
            ready_q      <= 1'b0;
            overrun_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_ok_q      <= 1'b0;
            data_q       <= '0;
        end else begin
            sync1_q <= bufGetWord;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;

            rd_pend_q <= req;
            rd_ok_q   <= rd_valid;
            if (rd_pend_q) begin
                data_q <= rd_ok_q ? rd_word_q : '0;
            end

            if (fill_active) begin
                fill_addr_q <= fill_last ? '0 : fill_addr_q + ADDR_W'(1);
            end

            case (state_q)
                ST_INIT: begin
                    if (fill_last) begin
                        state_q      <= ST_FILL;
                        ready_q      <= 1'b1;
                        fill_bank_q  <= 1'b1;
                        fill_frame_q <= 16'd1;
                    end
                end
                ST_FILL: begin
                    if (fill_last) begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                end
            endcase

            // Wrap read: swap banks if the idle bank is full, otherwise flag and keep serving the old bank.
            if (swap_req) begin
                if (swap_ok) begin
                    rd_bank_q    <= ~rd_bank_q;
                    frame_cnt_q  <= frame_cnt_q + 16'd1;
                    state_q      <= ST_FILL;
                    fill_bank_q  <= rd_bank_q;
                    fill_frame_q <= frame_cnt_q + 16'd2;
                    fill_addr_q  <= '0;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign dataWord  = data_q;
    assign oReady    = ready_q;
    assign oOverrun  = overrun_q;
    assign oFrameCnt = frame_cnt_q;

endmodule

// File: tb/tb_orb_frame_filler.sv
// Bench for orb_frame_filler: full-size instance plus a FRAME_WORDS=1000 instance sharing clock and reset.
// Expected responses come from a frame-level model (frame number, fill-complete time) and are queued per request.
// A monitor compares each response 4 clk after the request edge, and also checks the old value one clk earlier.
module tb_orb_frame_filler;

    localparam int AW = 11;
    localparam int WW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          get_b, get_s;
    logic [AW-1:0] ptr_b, ptr_s;
    logic [WW-1:0] dw_b, dw_s;
    logic          rdy_b, rdy_s, ovr_b, ovr_s;
    logic [15:0]   fc_b, fc_s;

    always #5 clk = ~clk;

    orb_frame_filler dut_b (
        .clk(clk), .reset(reset), .bufGetWord(get_b), .bufRdPointer(ptr_b),
        .dataWord(dw_b), .oReady(rdy_b), .oOverrun(ovr_b), .oFrameCnt(fc_b)
    );

    orb_frame_filler #(.FRAME_WORDS(1000)) dut_s (
        .clk(clk), .reset(reset), .bufGetWord(get_s), .bufRdPointer(ptr_s),
        .dataWord(dw_s), .oReady(rdy_s), .oOverrun(ovr_s), .oFrameCnt(fc_s)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int sel;
        int prev;
        int word;
        int fcnt;
        int ovr;
    } exp_t;

    exp_t q[$];

    // Model state per instance (0 = full size, 1 = reduced)
    int m_fw[2] = '{2048, 1000};
    int m_rel[2];
    int m_f[2];
    int m_ovr[2];
    int m_done[2];
    int m_last[2];

    function automatic int content(input int f, input int a);
        if (a == 0) return 'hF0F;
        if (a == 1) return f & 'hFFF;
        return (a + f) & 'hFFF;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int dw(input int sel);
        return (sel != 0) ? int'(dw_s) : int'(dw_b);
    endfunction

    function automatic int fc(input int sel);
        return (sel != 0) ? int'(fc_s) : int'(fc_b);
    endfunction

    function automatic int ovr(input int sel);
        return (sel != 0) ? int'(ovr_s) : int'(ovr_b);
    endfunction

    // r = cycle count at the negedge where reset is released; first fill write is on the next posedge.
    task automatic model_reset(input int r);
        for (int s = 0; s < 2; s++) begin
            m_rel[s]  = r;
            m_f[s]    = 0;
            m_ovr[s]  = 0;
            m_done[s] = r + 2 * m_fw[s];
            m_last[s] = 0;
        end
    endtask

    // c = posedge at which the request is consumed.
    // Bank 0 is full after posedge rel+fw; the next frame is full from posedge (swap + fw) on.
    task automatic model_read(input int sel, input int ptr, input int c, output exp_t e);
        int w;
        e.sel = sel;
        e.prev = m_last[sel];
        if (c < m_rel[sel] + m_fw[sel] + 1 || ptr >= m_fw[sel]) begin
            w = 0;
        end else begin
            w = content(m_f[sel], ptr);
            if (ptr == m_fw[sel] - 1) begin
                if (c >= m_done[sel]) begin
                    m_f[sel]    = (m_f[sel] + 1) & 'hFFFF;
                    m_done[sel] = c + m_fw[sel];
                end else begin
                    m_ovr[sel] = 1;
                end
            end
        end
        m_last[sel] = w;
        e.word = w;
        e.fcnt = m_f[sel];
        e.ovr  = m_ovr[sel];
    endtask

    task automatic set_get(input int sel, input logic v);
        if (sel != 0) get_s = v;
        else          get_b = v;
    endtask

    task automatic set_ptr(input int sel, input int p);
        if (sel != 0) ptr_s = AW'(p);
        else          ptr_b = AW'(p);
    endtask

    // Pointer settles 3 clk ahead, request is raised at a negedge and held for 'hold' clk.
    task automatic do_read(input int sel, input int ptr, input int hold);
        exp_t e;
        @(negedge clk);
        set_ptr(sel, ptr);
        repeat (3) @(negedge clk);
        model_read(sel, ptr, cyc + 3, e);
        q.push_back(e);
        set_get(sel, 1'b1);
        repeat (hold) @(negedge clk);
        set_get(sel, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: response lands after the 4th posedge following the request edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge get_b or posedge get_s);
            repeat (3) @(posedge clk);
            @(negedge clk);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: response with no expectation queued (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                check("data_latency", dw(e.sel), e.prev);
                @(posedge clk);
                @(negedge clk);
                check("data_word", dw(e.sel), e.word);
                check("frame_cnt", fc(e.sel), e.fcnt);
                check("overrun", ovr(e.sel), e.ovr);
            end
        end
    end

    initial begin
        int p, s, gap;
        exp_t e;
        reset = 1'b1;
        get_b = 1'b0;
        get_s = 1'b0;
        ptr_b = '0;
        ptr_s = '0;
        repeat (3) @(negedge clk);
        check("rst_data", int'(dw_b), 0);
        check("rst_ready", int'(rdy_b), 0);
        check("rst_overrun", int'(ovr_b), 0);
        check("rst_fcnt", int'(fc_b), 0);
        check("rst_ready_s", int'(rdy_s), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset(cyc);

        // Read before the initial fill completes returns zero
        do_read(0, 5, 6);
        check("early_ready", int'(rdy_b), 0);

        while (cyc < m_rel[0] + 2056) @(negedge clk);
        check("ready_b", int'(rdy_b), 1);
        check("ready_s", int'(rdy_s), 1);
        do_read(0, 0, 6);
        do_read(0, 1, 6);
        do_read(0, 5, 6);

        // Reduced frame: out-of-range pointer, then wrap at FRAME_WORDS-1
        do_read(1, 1000, 6);
        do_read(1, 999, 6);
        do_read(1, 1, 6);
        do_read(1, 5, 6);

        // Full sequential frame, swap at 2047
        for (int i = 0; i < 2048; i++) do_read(0, i, 6);
        do_read(0, 1, 6);
        do_read(0, 5, 6);

        // Wrap again while the refill is still running
        do_read(0, 2047, 6);
        do_read(0, 5, 6);

        // Long request level: one read only, pointer change mid-level ignored
        @(negedge clk);
        ptr_b = AW'(3);
        repeat (3) @(negedge clk);
        model_read(0, 3, cyc + 3, e);
        q.push_back(e);
        get_b = 1'b1;
        repeat (10) @(negedge clk);
        ptr_b = AW'(7);
        repeat (490) @(negedge clk);
        get_b = 1'b0;
        repeat (3) @(negedge clk);
        check("held_single_read", int'(dw_b), m_last[0]);
        check("held_fcnt", int'(fc_b), m_f[0]);

        // Randomised reads on both instances
        repeat (2100) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            s = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) p = m_fw[s] - 1;
            else p = int'($urandom_range(0, (s != 0) ? 1023 : 2047));
            do_read(s, p, 6);
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2000, 2200))
                                              : int'($urandom_range(0, 30));
            repeat (gap) @(negedge clk);
        end

        // Reset in the middle of a refill
        repeat (2100) @(negedge clk);
        do_read(0, 2047, 6);
        repeat (100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_data", int'(dw_b), 0);
        check("mid_rst_ready", int'(rdy_b), 0);
        check("mid_rst_overrun", int'(ovr_b), 0);
        check("mid_rst_fcnt", int'(fc_b), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset(cyc);
        while (cyc < m_rel[0] + 2047) @(negedge clk);
        check("ready_before_fill", int'(rdy_b), 0);
        @(negedge clk);
        check("ready_after_fill", int'(rdy_b), 1);
        do_read(0, 1, 6);
        do_read(0, 5, 6);

        repeat (10) @(negedge clk);
        check("sb_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
